c_tile_sched: RTL and testbench

Sequencer for the C-tile accumulation buffer (control_C) of the matrix-multiply datapath. For one output tile it drives the buffer's load/store position strobes over N accumulation passes of SI×SJ beats each. It then replays the finished tile out of the buffer as a result stream. It sits between the PE array's partial-sum stream and control_C, and owns all pass and beat bookkeeping.

---
 rtl/c_tile_sched_if.sv | 33 +++
 rtl/c_tile_sched.sv | 123 ++++++++++++
 tb/tb_c_tile_sched.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/c_tile_sched_if.sv
// Handshake/bus bundle between the C-tile scheduler and its environment
// (PE array, control_C buffer, result sink).
interface c_tile_sched_if #(
  parameter int DATA_W = 64,
  parameter int BW     = 6
);
  logic              start_in;
  logic [31:0]       N_in;
  logic              pe_valid_in;
  logic              pe_ready_out;
  logic              load_pos_bit_out;
  logic              store_pos_bit_out;
  logic [BW-1:0]     beat_idx_out;
  logic [31:0]       pass_idx_out;
  logic [DATA_W-1:0] rd_data_in;
  logic              res_ready_in;
  logic [DATA_W-1:0] res_data_out;
  logic              res_valid_out;
  logic              busy_out;
  logic              done_out;

  modport master (
    input  start_in, N_in, pe_valid_in, rd_data_in, res_ready_in,
    output pe_ready_out, load_pos_bit_out, store_pos_bit_out, beat_idx_out,
           pass_idx_out, res_data_out, res_valid_out, busy_out, done_out
  );

  modport slave (
    output start_in, N_in, pe_valid_in, rd_data_in, res_ready_in,
    input  pe_ready_out, load_pos_bit_out, store_pos_bit_out, beat_idx_out,
           pass_idx_out, res_data_out, res_valid_out, busy_out, done_out
  );
endinterface

// File: rtl/c_tile_sched.sv
// C-tile accumulation sequencer: N passes of BEATS load/store strobes into
// control_C, then a BEATS-long readout of the finished tile.
//
// state     | meaning
// S_IDLE    | waiting for start_in
// S_ACCUM   | accepting PE beats, one load strobe per pe_valid_in
// S_DRAIN   | no new loads, waiting for delayed store strobes to flush
// S_READOUT | issuing readout strobes on res_ready_in, returning rd_data
// S_DONE    | one-cycle completion pulse
module c_tile_sched #(
  parameter int DATA_W  = 64,
  parameter int SI      = 8,
  parameter int SJ      = 8,
  parameter int ACC_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  c_tile_sched_if.master  io
);
  localparam int BEATS = SI * SJ;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_DRAIN, S_READOUT, S_DONE} state_t;

  state_t              r_state, w_next;
  logic [31:0]         r_n, r_pass;
  logic [BW-1:0]       r_beat;
  logic                r_all_issued;
  logic [ACC_LAT-1:0]  r_ld_sr, r_rd_sr;
  logic [ACC_LAT-1:0]  w_ld_shift, w_rd_shift;
  logic [DATA_W-1:0]   r_res_data;
  logic                w_acc_fire, w_rd_fire, w_last_beat, w_final, w_rd_cap;

  assign w_acc_fire  = (r_state == S_ACCUM) && io.pe_valid_in;
  assign w_rd_fire   = (r_state == S_READOUT) && io.res_ready_in && !r_all_issued;
  assign w_last_beat = (r_beat == LAST_BEAT);
  assign w_final     = w_acc_fire && w_last_beat && (r_pass == (r_n - 32'd1));
  assign w_ld_shift  = r_ld_sr << 1;
  assign w_rd_shift  = r_rd_sr << 1;

  // rd_data is captured one stage before res_valid so both line up at ACC_LAT
  generate
    if (ACC_LAT == 1) begin : g_cap1
      assign w_rd_cap = w_rd_fire;
    end else begin : g_capn
      assign w_rd_cap = r_rd_sr[ACC_LAT-2];
    end
  endgenerate

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (io.start_in) w_next = (io.N_in == 32'd0) ? S_DONE : S_ACCUM;
      S_ACCUM:   if (w_final) w_next = S_DRAIN;
      S_DRAIN:   if (w_ld_shift == '0) w_next = S_READOUT;
      S_READOUT: if (r_all_issued && r_rd_sr[ACC_LAT-1] && (w_rd_shift == '0))
                   w_next = S_DONE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_n          <= '0;
      r_pass       <= '0;
      r_beat       <= '0;
      r_all_issued <= 1'b0;
      r_ld_sr      <= '0;
      r_rd_sr      <= '0;
      r_res_data   <= '0;
    end else begin
      r_state <= w_next;
      r_ld_sr <= w_ld_shift | ACC_LAT'(w_acc_fire);
      r_rd_sr <= w_rd_shift | ACC_LAT'(w_rd_fire);
      if (w_rd_cap) r_res_data <= io.rd_data_in;
      case (r_state)
        S_IDLE: begin
          if (io.start_in) begin
            r_n          <= io.N_in;
            r_beat       <= '0;
            r_pass       <= '0;
            r_all_issued <= 1'b0;
          end
        end
        S_ACCUM: begin
          if (w_acc_fire) begin
            if (w_last_beat) begin
              r_beat <= '0;
              r_pass <= r_pass + 32'd1;
            end else begin
              r_beat <= r_beat + BW'(1);
            end
          end
        end
        S_DRAIN: begin
          r_beat       <= '0;
          r_all_issued <= 1'b0;
        end
        S_READOUT: begin
          if (w_rd_fire) begin
            r_beat <= w_last_beat ? '0 : r_beat + BW'(1);
            if (w_last_beat) r_all_issued <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign io.pe_ready_out      = (r_state == S_ACCUM);
  assign io.load_pos_bit_out  = w_acc_fire || w_rd_fire;
  assign io.store_pos_bit_out = r_ld_sr[ACC_LAT-1];
  assign io.beat_idx_out      = r_beat;
  assign io.pass_idx_out      = r_pass;
  assign io.res_data_out      = r_res_data;
  assign io.res_valid_out     = r_rd_sr[ACC_LAT-1];
  assign io.busy_out          = (r_state == S_ACCUM) || (r_state == S_DRAIN) ||
                                (r_state == S_READOUT);
  assign io.done_out          = (r_state == S_DONE);
endmodule

// File: tb/tb_c_tile_sched.sv
// Bench for c_tile_sched: per-cycle comparison of every output against a
// schedule derived from the stimulus arrays (which cycles fire, and when).
module tb_c_tile_sched;
  localparam int DW    = 64;
  localparam int L     = 1;
  localparam int BEATS = 64;
  localparam int BW    = 6;
  localparam int MAXC  = 1200;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  c_tile_sched_if #(.DATA_W(DW), .BW(BW)) bus();
  c_tile_sched #(.DATA_W(DW), .SI(8), .SJ(8), .ACC_LAT(L)) dut (
    .clk(clk), .rst(rst), .io(bus)
  );

  int errors = 0;
  int checks = 0;

  bit          v_arr [MAXC];
  bit          r_arr [MAXC];
  logic [DW-1:0] d_arr [MAXC];
  bit          e_ld [MAXC], e_st [MAXC], e_rv [MAXC], e_done [MAXC], e_busy [MAXC], e_rdy [MAXC];
  logic [DW-1:0] e_rd [MAXC];
  int          e_beat [MAXC], e_pass [MAXC];
  int          done_c;
  int          obs_done;

  task automatic chk(input string tag, input int cyc, input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // vmode: 0 all valid, 1 random; rmode: 0 all ready, 1 alternating, 2 random
  task automatic fill(input int vmode, input int rmode);
    for (int j = 0; j < MAXC; j++) begin
      d_arr[j] = {$urandom, $urandom};
      v_arr[j] = (vmode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      case (rmode)
        0:       r_arr[j] = 1'b1;
        1:       r_arr[j] = (j % 2 == 0);
        default: r_arr[j] = ($urandom_range(0, 2) != 0);
      endcase
    end
  endtask

  // Cycle 0 is the cycle in which start_in is sampled in IDLE.
  task automatic plan(input int n);
    int c, k, last;
    for (int i = 0; i < MAXC; i++) begin
      e_ld[i] = 0; e_st[i] = 0; e_rv[i] = 0; e_done[i] = 0; e_busy[i] = 0; e_rdy[i] = 0;
      e_rd[i] = '0; e_beat[i] = -1; e_pass[i] = -1;
    end
    if (n == 0) begin
      done_c = 1;
      e_done[1] = 1;
      return;
    end
    c = 1; k = 0; last = 0;
    while (k < n * BEATS && c < MAXC - 8) begin
      e_rdy[c] = 1;
      if (v_arr[c]) begin
        e_ld[c] = 1; e_beat[c] = k % BEATS; e_pass[c] = k / BEATS;
        e_st[c + L] = 1;
        k++; last = c;
      end
      c++;
    end
    c = last + L + 1;
    k = 0;
    while (k < BEATS && c < MAXC - 8) begin
      if (r_arr[c]) begin
        e_ld[c] = 1; e_beat[c] = k;
        e_rv[c + L] = 1; e_rd[c + L] = d_arr[c + L - 1];
        k++; last = c;
      end
      c++;
    end
    done_c = last + L + 1;
    e_done[done_c] = 1;
    for (int i = 1; i < done_c; i++) e_busy[i] = 1;
  endtask

  task automatic run(input int n, input bit hold, input int abort_at);
    int last_j;
    bus.N_in = n;
    last_j = (abort_at > 0) ? abort_at : (hold ? done_c + 2 : done_c + 1);
    obs_done = -1;
    for (int j = 0; j <= last_j; j++) begin
      bus.start_in     = (j == 0) || hold;
      bus.pe_valid_in  = v_arr[j];
      bus.res_ready_in = r_arr[j];
      bus.rd_data_in   = d_arr[j];
      if (abort_at > 0 && j == abort_at) rst = 1'b1;
      @(negedge clk);
      chk("load",     j, bus.load_pos_bit_out,  e_ld[j]);
      chk("store",    j, bus.store_pos_bit_out, e_st[j]);
      chk("pe_ready", j, bus.pe_ready_out,      e_rdy[j]);
      chk("busy",     j, bus.busy_out,          e_busy[j]);
      chk("done",     j, bus.done_out,          e_done[j]);
      chk("res_vld",  j, bus.res_valid_out,     e_rv[j]);
      if (e_rv[j])        chk("res_data", j, bus.res_data_out, e_rd[j]);
      if (e_beat[j] >= 0) chk("beat_idx", j, bus.beat_idx_out, e_beat[j]);
      if (e_pass[j] >= 0) chk("pass_idx", j, bus.pass_idx_out, e_pass[j]);
      if (bus.done_out && obs_done < 0) obs_done = j;
      @(posedge clk); #1;
    end
    bus.start_in = 1'b0;
    if (abort_at == 0) chk("done_cycle", 0, obs_done, done_c);
  endtask

  task automatic check_idle_zero(input string tag);
    @(negedge clk);
    chk({tag, "_load"},  0, bus.load_pos_bit_out,  0);
    chk({tag, "_store"}, 0, bus.store_pos_bit_out, 0);
    chk({tag, "_rdy"},   0, bus.pe_ready_out,      0);
    chk({tag, "_busy"},  0, bus.busy_out,          0);
    chk({tag, "_done"},  0, bus.done_out,          0);
    chk({tag, "_vld"},   0, bus.res_valid_out,     0);
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    bus.start_in = 0; bus.N_in = 0; bus.pe_valid_in = 0; bus.res_ready_in = 0; bus.rd_data_in = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_load",  0, bus.load_pos_bit_out,  0);
    chk("rst_store", 0, bus.store_pos_bit_out, 0);
    chk("rst_rdy",   0, bus.pe_ready_out,      0);
    chk("rst_busy",  0, bus.busy_out,          0);
    chk("rst_done",  0, bus.done_out,          0);
    chk("rst_vld",   0, bus.res_valid_out,     0);
    chk("rst_data",  0, bus.res_data_out,      0);
    chk("rst_beat",  0, bus.beat_idx_out,      0);
    chk("rst_pass",  0, bus.pass_idx_out,      0);
    @(posedge clk); #1;
    rst = 1'b0;

    // N=2, no gaps, ready always
    fill(0, 0); plan(2); run(2, 0, 0);
    chk("tile_time_nogap", 0, obs_done, 2 * BEATS + L + BEATS + L + 1);

    // single gap at beat 4 (cycle 5)
    fill(0, 0); v_arr[5] = 1'b0; plan(2); run(2, 0, 0);
    chk("tile_time_gap", 0, obs_done, 2 * BEATS + L + BEATS + L + 2);

    // N=0
    fill(0, 0); plan(0); run(0, 0, 0);

    // readout with ready toggling
    fill(0, 1); plan(1); run(1, 0, 0);

    // randomized gaps and readout throttling
    for (int t = 0; t < 3; t++) begin
      n = $urandom_range(1, 2);
      fill(1, 2); plan(n); run(n, 0, 0);
    end

    // start held high: second tile accepted only from IDLE after DONE
    fill(0, 0); plan(1);
    e_rdy[done_c + 2] = 1; e_busy[done_c + 2] = 1; e_ld[done_c + 2] = 1;
    e_beat[done_c + 2] = 0; e_pass[done_c + 2] = 0;
    run(1, 1, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_idle_zero("hold_rst");

    // reset at pass 1 beat 10 (load #74 at cycle 75)
    fill(0, 0); plan(2); run(2, 0, 75);
    rst = 1'b0;
    bus.pe_valid_in = 1'b1;
    check_idle_zero("abort0");
    check_idle_zero("abort1");

    // normal tile after abort
    fill(0, 0); plan(1); run(1, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
